// File: rtl/comparator_pkg.sv
// Shared types and defaults for the tracking comparator.
// Holds the tracker state encoding and the default operand and counter widths.
package comparator_pkg;

  localparam int CMP_WIDTH   = 4;
  localparam int CMP_COUNT_W = 8;

  typedef enum logic {
    EMPTY = 1'b0,
    TRACK = 1'b1
  } track_state_e;

endpackage

// File: rtl/comparator_core.sv
// Combinational magnitude compare of two operands.
// The SIGNED parameter selects between unsigned and two's-complement ordering.
module comparator_core #(
  parameter int WIDTH  = 4,
  parameter int SIGNED = 0
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             eq,
  output logic             gt,
  output logic             lt
);

  logic gt_u;
  logic gt_s;

  assign gt_u = a > b;
  assign gt_s = $signed(a) > $signed(b);

  assign eq = a == b;
  assign gt = (SIGNED != 0) ? gt_s : gt_u;
  assign lt = !eq && !gt;

endmodule

// File: rtl/comparator_nbits_track.sv
// Registered a/b comparator with running max/min of a
// and a saturating counter of consecutive equal samples.
module comparator_nbits_track
  import comparator_pkg::*;
#(
  parameter int WIDTH   = CMP_WIDTH,
  parameter int SIGNED  = 0,
  parameter int COUNT_W = CMP_COUNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               clear,
  output logic               out_valid,
  output logic               equal,
  output logic               a_greater,
  output logic               b_greater,
  output logic [WIDTH-1:0]   max_val,
  output logic [WIDTH-1:0]   min_val,
  output logic [COUNT_W-1:0] eq_count
);

  track_state_e state_q;
  track_state_e state_d;

  logic [WIDTH-1:0]   max_d;
  logic [WIDTH-1:0]   min_d;
  logic [COUNT_W-1:0] cnt_d;

  logic ab_eq, ab_gt, ab_lt;
  logic max_eq, max_gt, max_lt;
  logic min_eq, min_gt, min_lt;
  logic unused_cmp;

  comparator_core #(
    .WIDTH (WIDTH),
    .SIGNED(SIGNED)
  ) u_ab (
    .a (a),
    .b (b),
    .eq(ab_eq),
    .gt(ab_gt),
    .lt(ab_lt)
  );

  comparator_core #(
    .WIDTH (WIDTH),
    .SIGNED(SIGNED)
  ) u_max (
    .a (a),
    .b (max_val),
    .eq(max_eq),
    .gt(max_gt),
    .lt(max_lt)
  );

  comparator_core #(
    .WIDTH (WIDTH),
    .SIGNED(SIGNED)
  ) u_min (
    .a (a),
    .b (min_val),
    .eq(min_eq),
    .gt(min_gt),
    .lt(min_lt)
  );

  assign unused_cmp = &{max_eq, max_lt, min_eq, min_gt};

  // A sample with clear seeds the tracker; clear alone empties it.
  always_comb begin
    state_d = state_q;
    max_d   = max_val;
    min_d   = min_val;
    cnt_d   = eq_count;
    if (in_valid) begin
      state_d = TRACK;
      if (clear || state_q == EMPTY) begin
        max_d = a;
        min_d = a;
      end else begin
        if (max_gt) max_d = a;
        if (min_lt) min_d = a;
      end
      if (!ab_eq)
        cnt_d = '0;
      else if (clear)
        cnt_d = COUNT_W'(1);
      else if (eq_count != '1)
        cnt_d = eq_count + COUNT_W'(1);
    end else if (clear) begin
      state_d = EMPTY;
      max_d   = '0;
      min_d   = '0;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= EMPTY;
      max_val  <= '0;
      min_val  <= '0;
      eq_count <= '0;
    end else begin
      state_q  <= state_d;
      max_val  <= max_d;
      min_val  <= min_d;
      eq_count <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      equal     <= 1'b0;
      a_greater <= 1'b0;
      b_greater <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        equal     <= ab_eq;
        a_greater <= ab_gt;
        b_greater <= ab_lt;
      end
    end
  end

endmodule

// File: tb/tb_comparator_nbits_track.sv
// Directed bench: unsigned and signed instances, both with a 2-bit streak
// counter, checked every cycle against an integer-valued reference model.
module tb_comparator_nbits_track;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [3:0] a;
  logic [3:0] b;
  logic       clear;

  logic       ov [2];
  logic       eq [2];
  logic       gt [2];
  logic       lt [2];
  logic [3:0] mx [2];
  logic [3:0] mn [2];
  logic [1:0] ec [2];

  int n_vec = 0;
  int n_err = 0;

  bit       e_ov [2];
  bit       e_eq [2];
  bit       e_gt [2];
  bit       e_lt [2];
  bit [3:0] e_mx [2];
  bit [3:0] e_mn [2];
  int       e_ec [2];
  bit       e_trk [2];

  always #5 clk = ~clk;

  comparator_nbits_track #(
    .WIDTH  (4),
    .SIGNED (0),
    .COUNT_W(2)
  ) u_uns (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .a        (a),
    .b        (b),
    .clear    (clear),
    .out_valid(ov[0]),
    .equal    (eq[0]),
    .a_greater(gt[0]),
    .b_greater(lt[0]),
    .max_val  (mx[0]),
    .min_val  (mn[0]),
    .eq_count (ec[0])
  );

  comparator_nbits_track #(
    .WIDTH  (4),
    .SIGNED (1),
    .COUNT_W(2)
  ) u_sgn (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .a        (a),
    .b        (b),
    .clear    (clear),
    .out_valid(ov[1]),
    .equal    (eq[1]),
    .a_greater(gt[1]),
    .b_greater(lt[1]),
    .max_val  (mx[1]),
    .min_val  (mn[1]),
    .eq_count (ec[1])
  );

  function automatic int val(input bit [3:0] x, input int s);
    if (s != 0 && x[3]) return int'(x) - 16;
    return int'(x);
  endfunction

  task automatic model();
    int va, vb;
    for (int k = 0; k < 2; k++) begin
      va = val(a, k);
      vb = val(b, k);
      if (rst) begin
        e_ov[k] = 0; e_eq[k] = 0; e_gt[k] = 0; e_lt[k] = 0;
        e_mx[k] = 0; e_mn[k] = 0; e_ec[k] = 0; e_trk[k] = 0;
      end else begin
        e_ov[k] = in_valid;
        if (in_valid) begin
          e_eq[k] = (va == vb);
          e_gt[k] = (va > vb);
          e_lt[k] = (va < vb);
          if (clear || !e_trk[k]) begin
            e_mx[k] = a;
            e_mn[k] = a;
          end else begin
            if (va > val(e_mx[k], k)) e_mx[k] = a;
            if (va < val(e_mn[k], k)) e_mn[k] = a;
          end
          if (va != vb) e_ec[k] = 0;
          else if (clear) e_ec[k] = 1;
          else if (e_ec[k] < 3) e_ec[k] = e_ec[k] + 1;
          e_trk[k] = 1;
        end else if (clear) begin
          e_mx[k] = 0; e_mn[k] = 0; e_ec[k] = 0; e_trk[k] = 0;
        end
      end
    end
  endtask

  task automatic cmp(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check();
    for (int k = 0; k < 2; k++) begin
      cmp($sformatf("out_valid[%0d]", k), int'(ov[k]), int'(e_ov[k]));
      cmp($sformatf("equal[%0d]", k), int'(eq[k]), int'(e_eq[k]));
      cmp($sformatf("a_greater[%0d]", k), int'(gt[k]), int'(e_gt[k]));
      cmp($sformatf("b_greater[%0d]", k), int'(lt[k]), int'(e_lt[k]));
      cmp($sformatf("max_val[%0d]", k), int'(mx[k]), int'(e_mx[k]));
      cmp($sformatf("min_val[%0d]", k), int'(mn[k]), int'(e_mn[k]));
      cmp($sformatf("eq_count[%0d]", k), int'(ec[k]), e_ec[k]);
    end
  endtask

  task automatic step(input bit r, input bit v, input bit c,
                      input bit [3:0] aa, input bit [3:0] bb);
    rst = r; in_valid = v; clear = c; a = aa; b = bb;
    @(posedge clk);
    model();
    #1;
    check();
  endtask

  initial begin
    rst = 1; in_valid = 0; clear = 0; a = 0; b = 0;
    @(negedge clk);

    step(1, 1, 0, 9, 9);
    step(1, 1, 0, 9, 9);
    cmp("rst_ov", int'(ov[0]), 0);
    cmp("rst_max", int'(mx[0]), 0);
    cmp("rst_eq", int'(eq[1]), 0);

    step(0, 1, 0, 13, 3);
    cmp("pin_gt_13_3", int'(gt[0]), 1);
    cmp("pin_seed_max", int'(mx[0]), 13);
    cmp("pin_seed_min", int'(mn[0]), 13);
    step(0, 1, 0, 5, 7);
    cmp("pin_lt_5_7", int'(lt[0]), 1);
    step(0, 1, 0, 5, 5);
    cmp("pin_eq_5_5", int'(eq[0]), 1);
    cmp("pin_ov_3rd", int'(ov[0]), 1);
    step(0, 0, 0, 2, 9);
    cmp("pin_hold_eq", int'(eq[0]), 1);
    cmp("pin_ov_gap", int'(ov[0]), 0);

    step(0, 1, 0, 4'b1000, 4'b0111);
    cmp("pin_sgn_lt", int'(lt[1]), 1);
    cmp("pin_uns_gt", int'(gt[0]), 1);

    step(0, 0, 1, 0, 0);
    cmp("pin_clr_max", int'(mx[0]), 0);
    step(0, 1, 0, 5, 6);
    step(0, 1, 0, 13, 14);
    step(0, 1, 0, 0, 1);
    step(0, 1, 0, 9, 10);
    cmp("pin_trk_max_u", int'(mx[0]), 13);
    cmp("pin_trk_min_u", int'(mn[0]), 0);
    cmp("pin_trk_max_s", int'(mx[1]), 5);
    cmp("pin_trk_min_s", int'(mn[1]), 9);

    step(0, 1, 1, 3, 3);
    cmp("pin_seed3_max", int'(mx[0]), 3);
    cmp("pin_seed3_min", int'(mn[0]), 3);
    cmp("pin_cnt1", int'(ec[0]), 1);
    step(0, 1, 0, 3, 3);
    cmp("pin_cnt2", int'(ec[0]), 2);
    step(0, 1, 0, 6, 6);
    cmp("pin_cnt3", int'(ec[0]), 3);
    step(0, 1, 0, 3, 3);
    cmp("pin_cnt3_sat", int'(ec[0]), 3);
    step(0, 1, 0, 2, 2);
    cmp("pin_cnt3_sat2", int'(ec[0]), 3);
    step(0, 0, 0, 1, 7);
    cmp("pin_cnt_gap", int'(ec[0]), 3);
    step(0, 1, 0, 1, 7);
    cmp("pin_cnt_zero", int'(ec[0]), 0);

    step(0, 1, 0, 1, 0);
    cmp("pin_edge_gt", int'(gt[0]), 1);
    step(0, 1, 0, 1, 1);
    cmp("pin_edge_eq", int'(eq[0]), 1);
    step(0, 1, 0, 0, 1);
    cmp("pin_edge_lt", int'(lt[0]), 1);
    step(0, 1, 0, 0, 0);
    cmp("pin_edge_eq2", int'(eq[0]), 1);

    step(0, 1, 0, 15, 2);
    step(1, 1, 1, 4, 4);
    step(0, 0, 0, 4, 4);
    step(0, 1, 0, 6, 1);
    cmp("pin_post_rst_max", int'(mx[0]), 6);
    cmp("pin_post_rst_min", int'(mn[0]), 6);
    step(0, 1, 0, 4'b1110, 4'b0010);
    step(0, 1, 0, 4'b0111, 4'b0111);
    step(0, 0, 1, 0, 0);
    step(0, 1, 0, 4'b1000, 4'b1000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
